// File: rtl/bulls_cows_engine_if.sv
// Keypad/secret/control inputs and score/status outputs of the Bulls-and-Cows engine.
// The master side is the keypad/display glue; the slave side is the engine.
interface bulls_cows_engine_if #(
  parameter int unsigned N_DIGITS  = 4,
  parameter int unsigned MAX_TRIES = 10
);
  localparam int unsigned SW = $clog2(N_DIGITS + 1);
  localparam int unsigned CW = SW;
  localparam int unsigned TW = $clog2(MAX_TRIES + 1);
  localparam int unsigned DW = 4 * N_DIGITS;

  logic          key_valid;
  logic [3:0]    key_code;
  logic          key_del;
  logic          key_enter;
  logic          secret_load;
  logic [DW-1:0] secret;
  logic          new_game;

  logic [1:0]    state;
  logic [DW-1:0] guess_disp;
  logic [CW-1:0] digit_cnt;
  logic [SW-1:0] strike;
  logic [SW-1:0] ball;
  logic          result_valid;
  logic [TW-1:0] tries;
  logic          guess_err;
  logic          secret_err;
  logic          win;
  logic          lose;

  modport master (
    output key_valid, key_code, key_del, key_enter, secret_load, secret, new_game,
    input  state, guess_disp, digit_cnt, strike, ball, result_valid, tries,
           guess_err, secret_err, win, lose
  );

  modport slave (
    input  key_valid, key_code, key_del, key_enter, secret_load, secret, new_game,
    output state, guess_disp, digit_cnt, strike, ball, result_valid, tries,
           guess_err, secret_err, win, lose
  );
endinterface

// File: rtl/bulls_cows_engine.sv
// Sequential Bulls-and-Cows engine: loadable secret, buffered guess entry with delete,
// one-digit-per-cycle scoring, duplicate checks and an attempt limit.
module bulls_cows_engine #(
  parameter int unsigned N_DIGITS  = 4,
  parameter int unsigned MAX_TRIES = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  bulls_cows_engine_if.slave bus
);
  localparam int unsigned SW = $clog2(N_DIGITS + 1);
  localparam int unsigned CW = SW;
  localparam int unsigned TW = $clog2(MAX_TRIES + 1);
  localparam int unsigned DW = 4 * N_DIGITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENTRY = 2'd1,
    S_SCORE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] secret_q, secret_d;
  logic [SW-1:0] idx_q, idx_d;
  logic [SW-1:0] acc_s_q, acc_s_d;
  logic [SW-1:0] acc_b_q, acc_b_d;
  logic [SW-1:0] strike_q, strike_d;
  logic [SW-1:0] ball_q, ball_d;
  logic [TW-1:0] tries_q, tries_d;
  logic          win_q, win_d;
  logic          lose_q, lose_d;
  logic          rv_q, rv_d;
  logic          gerr_q, gerr_d;
  logic          serr_q, serr_d;

  logic          cur_strike;
  logic          cur_ball;
  logic          secret_ok;
  logic          guess_ok;

  function automatic logic all_distinct(input logic [DW-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      for (int j = i + 1; j < int'(N_DIGITS); j++) begin
        if (v[4*i +: 4] == v[4*j +: 4]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  function automatic logic all_bcd(input logic [DW-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  assign secret_ok = all_bcd(bus.secret) && all_distinct(bus.secret);
  assign guess_ok  = (cnt_q == CW'(N_DIGITS)) && all_distinct(buf_q);

  // Classify guess digit idx_q against the latched secret; idx_q == N_DIGITS matches nothing.
  always_comb begin
    cur_strike = 1'b0;
    cur_ball   = 1'b0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (SW'(i) == idx_q) begin
        for (int j = 0; j < int'(N_DIGITS); j++) begin
          if (buf_q[4*i +: 4] == secret_q[4*j +: 4]) begin
            if (i == j) cur_strike = 1'b1;
            else        cur_ball   = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      buf_q    <= '0;
      cnt_q    <= '0;
      secret_q <= '0;
      idx_q    <= '0;
      acc_s_q  <= '0;
      acc_b_q  <= '0;
      strike_q <= '0;
      ball_q   <= '0;
      tries_q  <= '0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
      rv_q     <= 1'b0;
      gerr_q   <= 1'b0;
      serr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      secret_q <= secret_d;
      idx_q    <= idx_d;
      acc_s_q  <= acc_s_d;
      acc_b_q  <= acc_b_d;
      strike_q <= strike_d;
      ball_q   <= ball_d;
      tries_q  <= tries_d;
      win_q    <= win_d;
      lose_q   <= lose_d;
      rv_q     <= rv_d;
      gerr_q   <= gerr_d;
      serr_q   <= serr_d;
    end
  end

  // Next state; input priority new_game > secret_load > enter > delete > digit.
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    secret_d = secret_q;
    idx_d    = idx_q;
    acc_s_d  = acc_s_q;
    acc_b_d  = acc_b_q;
    strike_d = strike_q;
    ball_d   = ball_q;
    tries_d  = tries_q;
    win_d    = win_q;
    lose_d   = lose_q;
    rv_d     = 1'b0;
    gerr_d   = 1'b0;
    serr_d   = 1'b0;

    if (bus.new_game) begin
      state_d  = S_IDLE;
      buf_d    = '0;
      cnt_d    = '0;
      strike_d = '0;
      ball_d   = '0;
      tries_d  = '0;
      win_d    = 1'b0;
      lose_d   = 1'b0;
    end else if (bus.secret_load && (state_q != S_SCORE)) begin
      if (secret_ok) begin
        state_d  = S_ENTRY;
        secret_d = bus.secret;
        buf_d    = '0;
        cnt_d    = '0;
        strike_d = '0;
        ball_d   = '0;
        tries_d  = '0;
        win_d    = 1'b0;
        lose_d   = 1'b0;
      end else begin
        serr_d = 1'b1;
      end
    end else begin
      case (state_q)
        S_ENTRY: begin
          if (bus.key_enter) begin
            if (guess_ok) begin
              state_d = S_SCORE;
              idx_d   = '0;
              acc_s_d = '0;
              acc_b_d = '0;
            end else begin
              gerr_d = 1'b1;
            end
          end else if (bus.key_del) begin
            if (cnt_q != '0) begin
              buf_d = buf_q >> 4;
              cnt_d = cnt_q - CW'(1);
            end
          end else if (bus.key_valid) begin
            if ((bus.key_code <= 4'd9) && (cnt_q < CW'(N_DIGITS))) begin
              buf_d = {buf_q[DW-5:0], bus.key_code};
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        S_SCORE: begin
          if (idx_q < SW'(N_DIGITS)) begin
            acc_s_d = acc_s_q + SW'(cur_strike);
            acc_b_d = acc_b_q + SW'(cur_ball);
            idx_d   = idx_q + SW'(1);
          end else begin
            // Publish the accumulated result and decide the game outcome.
            strike_d = acc_s_q;
            ball_d   = acc_b_q;
            rv_d     = 1'b1;
            tries_d  = tries_q + TW'(1);
            buf_d    = '0;
            cnt_d    = '0;
            if (acc_s_q == SW'(N_DIGITS)) begin
              win_d   = 1'b1;
              state_d = S_DONE;
            end else if ((tries_q + TW'(1)) == TW'(MAX_TRIES)) begin
              lose_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_ENTRY;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.state        = state_q;
  assign bus.guess_disp   = buf_q;
  assign bus.digit_cnt    = cnt_q;
  assign bus.strike       = strike_q;
  assign bus.ball         = ball_q;
  assign bus.result_valid = rv_q;
  assign bus.tries        = tries_q;
  assign bus.guess_err    = gerr_q;
  assign bus.secret_err   = serr_q;
  assign bus.win          = win_q;
  assign bus.lose         = lose_q;
endmodule

// File: tb/tb_bulls_cows_engine.sv
// Bench for bulls_cows_engine: directed game scenarios followed by random keypad traffic,
// checked against a queue-based game model.
module tb_bulls_cows_engine;
  localparam int unsigned N  = 4;
  localparam int unsigned MT = 3;
  localparam int unsigned DW = 4 * N;

  localparam int ST_IDLE  = 0;
  localparam int ST_ENTRY = 1;
  localparam int ST_SCORE = 2;
  localparam int ST_DONE  = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bulls_cows_engine_if #(.N_DIGITS(N), .MAX_TRIES(MT)) bus ();

  bulls_cows_engine #(.N_DIGITS(N), .MAX_TRIES(MT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Game model: m_q holds entered digits oldest-first, m_sec[i] is secret digit i.
  int m_state;
  int m_q[$];
  int m_sec[N];
  int m_tries, m_strike, m_ball;
  bit m_win, m_lose;

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_disp();
    logic [31:0] v;
    v = 0;
    foreach (m_q[k]) v = v * 16 + 32'(m_q[k]);
    return v;
  endfunction

  function automatic bit uniq(input int d[$]);
    for (int i = 0; i < d.size(); i++)
      for (int j = 0; j < d.size(); j++)
        if (i != j && d[i] == d[j]) return 0;
    return 1;
  endfunction

  function automatic bit secret_valid(input logic [DW-1:0] s);
    int d[$];
    for (int i = 0; i < int'(N); i++) begin
      if (int'(s[4*i +: 4]) > 9) return 0;
      d.push_back(int'(s[4*i +: 4]));
    end
    return uniq(d);
  endfunction

  task automatic model_clear_game();
    m_q.delete();
    m_tries = 0; m_strike = 0; m_ball = 0; m_win = 0; m_lose = 0;
  endtask

  task automatic model_reset();
    model_clear_game();
    m_state = ST_IDLE;
    for (int i = 0; i < int'(N); i++) m_sec[i] = 0;
  endtask

  task automatic model_step(input bit kv, input int kc, input bit kd, input bit ke,
                            input bit sl, input logic [DW-1:0] sec, input bit ng,
                            output bit ge, output bit se);
    ge = 0; se = 0;
    if (ng) begin
      model_clear_game();
      m_state = ST_IDLE;
    end else if (sl && m_state != ST_SCORE) begin
      if (secret_valid(sec)) begin
        for (int i = 0; i < int'(N); i++) m_sec[i] = int'(sec[4*i +: 4]);
        model_clear_game();
        m_state = ST_ENTRY;
      end else se = 1;
    end else if (m_state == ST_ENTRY) begin
      if (ke) begin
        if (m_q.size() == int'(N) && uniq(m_q)) m_state = ST_SCORE;
        else ge = 1;
      end else if (kd) begin
        if (m_q.size() > 0) void'(m_q.pop_back());
      end else if (kv && kc <= 9 && m_q.size() < int'(N)) begin
        m_q.push_back(kc);
      end
    end
  endtask

  // Positional guess digit i is the i-th newest entry.
  task automatic model_finish_score();
    int s, b, g;
    s = 0; b = 0;
    for (int i = 0; i < int'(N); i++) begin
      g = m_q[m_q.size() - 1 - i];
      if (g == m_sec[i]) s++;
      else foreach (m_sec[j]) if (m_sec[j] == g) b++;
    end
    m_strike = s; m_ball = b; m_tries++;
    m_q.delete();
    if (s == int'(N)) begin m_win = 1; m_state = ST_DONE; end
    else if (m_tries == int'(MT)) begin m_lose = 1; m_state = ST_DONE; end
    else m_state = ST_ENTRY;
  endtask

  task automatic check_all(input string tag, input bit rv, input bit ge, input bit se);
    chk({tag, ".state"},  32'(bus.state),        32'(m_state));
    chk({tag, ".disp"},   32'(bus.guess_disp),   m_disp());
    chk({tag, ".cnt"},    32'(bus.digit_cnt),    32'(m_q.size()));
    chk({tag, ".strike"}, 32'(bus.strike),       32'(m_strike));
    chk({tag, ".ball"},   32'(bus.ball),         32'(m_ball));
    chk({tag, ".tries"},  32'(bus.tries),        32'(m_tries));
    chk({tag, ".win"},    32'(bus.win),          32'(m_win));
    chk({tag, ".lose"},   32'(bus.lose),         32'(m_lose));
    chk({tag, ".rv"},     32'(bus.result_valid), 32'(rv));
    chk({tag, ".gerr"},   32'(bus.guess_err),    32'(ge));
    chk({tag, ".serr"},   32'(bus.secret_err),   32'(se));
  endtask

  // Called at a negedge: drive pulses for one cycle, then check at the following negedge.
  task automatic step(input string tag, input bit kv, input int kc, input bit kd, input bit ke,
                      input bit sl, input logic [DW-1:0] sec, input bit ng);
    bit ge, se;
    bus.key_valid = kv; bus.key_code = 4'(kc); bus.key_del = kd; bus.key_enter = ke;
    bus.secret_load = sl; bus.secret = sec; bus.new_game = ng;
    @(negedge clk);
    bus.key_valid = 0; bus.key_del = 0; bus.key_enter = 0; bus.secret_load = 0; bus.new_game = 0;
    model_step(kv, kc, kd, ke, sl, sec, ng, ge, se);
    check_all(tag, 0, ge, se);
  endtask

  task automatic digit(input int d);   step("digit", 1, d, 0, 0, 0, '0, 0); endtask
  task automatic del();                step("del",   0, 0, 1, 0, 0, '0, 0); endtask
  task automatic enter();              step("enter", 0, 0, 0, 1, 0, '0, 0); endtask
  task automatic newgame();            step("ngame", 0, 0, 0, 0, 0, '0, 1); endtask
  task automatic load(input logic [DW-1:0] s); step("load", 0, 0, 0, 0, 1, s, 0); endtask

  task automatic type_value(input logic [DW-1:0] v);
    for (int i = int'(N) - 1; i >= 0; i--) digit(int'(v[4*i +: 4]));
  endtask

  task automatic wait_score(input string tag);
    repeat (N) begin
      @(negedge clk);
      chk({tag, ".busy"}, 32'(bus.state), ST_SCORE);
      chk({tag, ".rv0"},  32'(bus.result_valid), 0);
    end
    @(negedge clk);
    model_finish_score();
    check_all(tag, 1, 0, 0);
  endtask

  task automatic guess(input logic [DW-1:0] v);
    type_value(v);
    enter();
    wait_score("score");
  endtask

  task automatic reset_mid_score(input int k);
    repeat (k) @(negedge clk);
    #2 rst_n = 0;
    #1 model_reset();
    check_all("async_rst", 0, 0, 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic abort_mid_score(input int k);
    repeat (k) begin
      @(negedge clk);
      chk("abort.busy", 32'(bus.state), ST_SCORE);
    end
    newgame();
  endtask

  function automatic logic [DW-1:0] rand_secret();
    int pool[10];
    int j, t;
    logic [DW-1:0] v;
    if ($urandom_range(0, 99) < 25) return DW'($urandom);
    for (int i = 0; i < 10; i++) pool[i] = i;
    for (int i = 9; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = pool[i]; pool[i] = pool[j]; pool[j] = t;
    end
    v = '0;
    for (int i = 0; i < int'(N); i++) v[4*i +: 4] = 4'(pool[i]);
    return v;
  endfunction

  initial begin
    bit kv, kd, ke, sl, ng;
    int kc, r;
    logic [DW-1:0] sec;

    rst_n = 0;
    bus.key_valid = 0; bus.key_code = 0; bus.key_del = 0; bus.key_enter = 0;
    bus.secret_load = 0; bus.secret = '0; bus.new_game = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset", 0, 0, 0);
    rst_n = 1;

    // No bulls or cows, then a mixed result, then a win.
    load(16'h1234);
    guess(16'h5678);
    chk("t1.strike", 32'(bus.strike), 0);
    chk("t1.ball",   32'(bus.ball),   0);
    chk("t1.tries",  32'(bus.tries),  1);
    chk("t1.state",  32'(bus.state),  ST_ENTRY);
    guess(16'h1243);
    chk("t2.strike", 32'(bus.strike), 2);
    chk("t2.ball",   32'(bus.ball),   2);
    guess(16'h1234);
    chk("t3.strike", 32'(bus.strike), 4);
    chk("t3.win",    32'(bus.win),    1);
    chk("t3.lose",   32'(bus.lose),   0);
    chk("t3.state",  32'(bus.state),  ST_DONE);
    digit(5);
    enter();
    chk("done.keys", 32'(bus.digit_cnt), 0);

    // Secret and guess rejection.
    newgame();
    load(16'h1123);
    chk("serr.state", 32'(bus.state), ST_IDLE);
    load(16'h12A4);
    load(16'h1234);
    digit(1); digit(1); digit(2);
    enter();
    digit(3);
    enter();
    chk("gerr.tries", 32'(bus.tries), 0);

    // Edit buffer: deletes, underflow, overflow.
    repeat (5) del();
    digit(1); digit(2); digit(3); del(); digit(9); digit(4); digit(7); digit(12);
    chk("edit.disp", 32'(bus.guess_disp), 32'h1294);
    chk("edit.cnt",  32'(bus.digit_cnt),  4);

    // Priority: secret_load beats enter; new_game beats secret_load.
    step("prio1", 1, 3, 1, 1, 1, 16'h5678, 0);
    chk("prio1.cnt", 32'(bus.digit_cnt), 0);
    step("prio2", 1, 3, 0, 0, 1, 16'h0123, 1);
    chk("prio2.state", 32'(bus.state), ST_IDLE);

    // Attempt limit reached without a win.
    load(16'h1234);
    guess(16'h5678);
    guess(16'h4321);
    chk("lose.ball", 32'(bus.ball), 4);
    guess(16'h5670);
    chk("lose.lose",  32'(bus.lose),  1);
    chk("lose.win",   32'(bus.win),   0);
    chk("lose.state", 32'(bus.state), ST_DONE);

    // Abort and reset during scoring.
    load(16'h0123);
    type_value(16'h3210); enter();
    abort_mid_score(2);
    load(16'h0123);
    type_value(16'h3210); enter();
    abort_mid_score(int'(N));
    load(16'h0123);
    type_value(16'h3210); enter();
    reset_mid_score(1);

    // Random traffic.
    for (int it = 0; it < 400; it++) begin
      ng = ($urandom_range(0, 99) < 3);
      sl = (m_state == ST_IDLE || m_state == ST_DONE) ? ($urandom_range(0, 99) < 60)
                                                       : ($urandom_range(0, 99) < 5);
      ke = (m_q.size() == int'(N)) ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 8);
      kd = ($urandom_range(0, 99) < 12);
      kv = ($urandom_range(0, 99) < 75);
      if (m_q.size() < int'(N) && $urandom_range(0, 99) < 60) kc = m_sec[int'(N) - 1 - m_q.size()];
      else kc = int'($urandom_range(0, 15));
      sec = rand_secret();
      step("rnd", kv, kc, kd, ke, sl, sec, ng);
      if (m_state == ST_SCORE) begin
        r = int'($urandom_range(0, 99));
        if (r < 12)      abort_mid_score(int'($urandom_range(0, N)));
        else if (r < 18) reset_mid_score(int'($urandom_range(0, N)));
        else             wait_score("rnd_score");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bulls_cows_engine.md
# bulls_cows_engine

Parametrised, sequential Bulls-and-Cows game engine. It replaces the fixed 4-digit, hard-wired-answer datapath with a loadable secret, buffered guess entry with delete, multi-cycle scoring, duplicate checking and an attempt limit with win/lose status. It sits between the keypad decode/edge-trigger front end and the LCD/LED display submodules.

## Interface
- N_DIGITS, 4, digits per secret/guess (legal 2..8); each digit is 4-bit BCD 0-9
- MAX_TRIES, 10, scored guesses allowed per game (legal 1..255)
- derived: SW = $clog2(N_DIGITS+1), CW = SW, TW = $clog2(MAX_TRIES+1)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- key_valid  in  1  one-cycle pulse: key_code is a new digit
- key_code  in  4  digit 0-9; codes 10-15 ignored
- key_del  in  1  one-cycle pulse: delete newest digit
- key_enter  in  1  one-cycle pulse: submit guess
- secret_load  in  1  one-cycle pulse: load secret and start game
- secret  in  4*N_DIGITS  secret digits, digit 0 in [3:0]
- new_game  in  1  one-cycle pulse: abort, return to IDLE
- state  out  2  0 IDLE, 1 ENTRY, 2 SCORE, 3 DONE
- guess_disp  out  4*N_DIGITS  entry buffer, newest digit in [3:0]
- digit_cnt  out  CW  digits currently entered
- strike  out  SW  strikes of last scored guess
- ball  out  SW  balls of last scored guess
- result_valid  out  1  one-cycle pulse: strike/ball updated
- tries  out  TW  scored guesses this game
- guess_err  out  1  one-cycle pulse: enter rejected
- secret_err  out  1  one-cycle pulse: secret rejected
- win  out  1  level, set on all-strike result
- lose  out  1  level, set on last try without win

## Operation
- Reset: state IDLE; all outputs, buffer, tries, secret register 0.
- Input priority within a cycle: new_game > secret_load > key_enter > key_del > key_valid; lower-priority pulses that cycle are dropped.
- new_game, any state: go IDLE; clear buffer, digit_cnt, strike, ball, tries, win, lose.
- secret_load, accepted in IDLE, ENTRY or DONE (ignored in SCORE): if all digits are ≤9 and pairwise distinct, latch secret, clear buffer/tries/strike/ball/win/lose, go ENTRY; otherwise pulse secret_err, no other state change.
- ENTRY, key_valid with code ≤9 and digit_cnt<N_DIGITS: buffer shifts left 4 bits, new digit into [3:0], digit_cnt+1. At digit_cnt=N_DIGITS, digits ignored (no wrap, no shift-out).
- ENTRY, key_del with digit_cnt>0: buffer shifts right 4 bits (zero fill), digit_cnt-1; at 0, no effect.
- ENTRY, key_enter: if digit_cnt=N_DIGITS and the buffer digits are pairwise distinct, go SCORE; otherwise pulse guess_err and stay in ENTRY, with buffer and tries unchanged.
- key inputs are ignored in IDLE, SCORE and DONE.
- SCORE: index i runs 0..N_DIGITS-1, one guess digit per cycle. Guess digit i is a strike if it equals secret digit i, and a ball if it equals any secret digit j≠i. Increments go to internal accumulators, cleared on SCORE entry.
- End of SCORE: strike/ball outputs load the accumulators, result_valid pulses, tries+1. Buffer and digit_cnt clear.
  - strike=N_DIGITS: win=1, go DONE.
  - Else tries reaches MAX_TRIES: lose=1, go DONE.
  - Else go ENTRY.
- DONE: strike/ball/tries/win/lose hold until new_game or secret_load.
- Invariant: strike+ball ≤ N_DIGITS; win and lose are never both 1.

## Timing
- Enter accepted at edge t: state=SCORE from t+1. Scoring occupies edges t+1..t+N_DIGITS. strike/ball/tries/result_valid/win/lose update at edge t+N_DIGITS+1, and state leaves SCORE on the same edge.
- guess_err and secret_err assert the cycle after the offending pulse, for exactly one cycle.
- Digit/delete effects are visible on guess_disp one cycle after the pulse.
- new_game during SCORE aborts at the next edge: no result_valid, tries unchanged.
- rst_n asserted mid-SCORE clears asynchronously; no partial result is ever presented.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- Defaults, secret 1234, enter 5,6,7,8 then enter → result_valid at t+5, strike=0, ball=0, tries=1, state ENTRY.
- Secret 1234, guess 1243 → strike=2, ball=2. Then guess 1234 → strike=4, win=1, state DONE; further keys ignored.
- Secret 1123 → secret_err pulse, state stays IDLE. Guess with 3 digits, or guess 1123 → guess_err pulse, tries unchanged.
- Entry 1,2,3 then del, 9,4, then extra key 7 → guess_disp=0x1294, digit_cnt=4 (7 ignored).
- MAX_TRIES=2, secret 1234, guesses 5678 and 4321 → second result strike=0, ball=4, lose=1, win=0, state DONE.
- N_DIGITS=3, secret 012, guess 210 mid-score new_game → IDLE next edge, no result_valid. Also assert rst_n mid-SCORE → all outputs 0 immediately.
